pipe_stage_reg: RTL
===================

// Module: pipe_stage_reg
// PURPOSE
//  Generic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) driven by the global stall vector.
//  Adds a valid bit, an explicit flush, true hold under downstream stall, illegal-stall detection,
//  and saturating bubble/hold performance counters.
//  Sits between stage SRC_STAGE and SRC_STAGE+1; payload is a flattened packed struct of DATA_W bits.
// PARAMETERS
//  DATA_W      64   payload width (packed reg_t/hilo_t bundle)
//  STALL_W     6    width of global stall vector
//  SRC_STAGE   3    index of upstream stage in stall; downstream index = SRC_STAGE+1 (must be < STALL_W)
//  CNT_W       16   width of perf counters
//  BUBBLE_DATA '0   payload value loaded on reset, flush or bubble
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous reset, active-low (asserted when rst == RST_ENABLE == 1'b0)
//  stall      in   STALL_W  global stall vector, bit i = stage i stalled
//  flush      in   1        kill contents of this register (exception/branch squash)
//  clr_cnt    in   1        synchronous clear of perf counters and stall_err
//  in_valid   in   1        upstream payload valid
//  in_data    in   DATA_W   upstream payload
//  out_valid  out  1        registered valid to downstream stage
//  out_data   out  DATA_W   registered payload to downstream stage
//  bubble_cnt out  CNT_W    bubbles inserted since last clear (saturating)
//  hold_cnt   out  CNT_W    cycles held since last clear (saturating)
//  stall_err  out  1        sticky: illegal stall pattern seen
// BEHAVIOUR
//  Let S = stall[SRC_STAGE], D = stall[SRC_STAGE+1]. One update per rising clk, priority top-down:
//  1 reset (rst==0): out_valid=0, out_data=BUBBLE_DATA, bubble_cnt=0, hold_cnt=0, stall_err=0.
//  2 flush=1: out_valid=0, out_data=BUBBLE_DATA; counters unchanged; overrides any stall.
//  3 bubble (S=1,D=0): out_valid=0, out_data=BUBBLE_DATA; bubble_cnt+=1.
//  4 hold (D=1): out_valid/out_data keep value; hold_cnt+=1.
//     If additionally S=0 (upstream advancing into stalled downstream): stall_err<=1 (sticky); still hold.
//  5 advance (S=0,D=0): out_valid<=in_valid, out_data<=in_data (in_data ignored content-wise if !in_valid but still loaded).
//  - Latency 1 cycle in advance case; no combinational path from any input to any output.
//  - Counters saturate at {CNT_W{1'b1}}; never wrap.
//  - clr_cnt=1 (no reset): counters and stall_err <= 0 that cycle; an increment in the same cycle is dropped;
//    payload/valid follow rules 2-5 unaffected.
//  - flush with S=1,D=0 counts no bubble; flush with D=1 counts no hold and raises no stall_err.
//  - Reset mid-hold: register cleared, hold discarded; first post-reset cycle follows rules 2-5.
//  - Stall bits other than S and D are ignored.
//  - Elaboration error if SRC_STAGE+1 >= STALL_W or DATA_W < 1.
// TESTING
//  T1 rst=0 two cycles with in_valid=1,in_data=0xDEAD -> out_valid=0, out_data=0, counters=0, stall_err=0.
//  T2 stall=0, in_data=0x1234 valid -> next cycle out_data=0x1234, out_valid=1; stream of 8 values emerges in order, 1-cycle lag.
//  T3 load 0xAA, then stall=6'b011000 (S=1,D=1) 3 cycles -> out_data stays 0xAA, hold_cnt=3; then stall=6'b001000 -> out_valid=0, bubble_cnt=1.
//  T4 stall=6'b010000 (S=0,D=1) 1 cycle -> out held, stall_err=1 and stays 1 after stall clears until clr_cnt.
//  T5 flush=1 with stall=6'b011000 and out holding 0x55 -> out_valid=0, out_data=0, hold_cnt unchanged.
//  T6 CNT_W=4: 20 bubble cycles -> bubble_cnt=15 (saturated); clr_cnt with bubble same cycle -> bubble_cnt=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with valid, flush, stall hold,
// illegal-stall detection and saturating bubble/hold counters.
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int STALL_W = 6,
  parameter int SRC_STAGE = 3,
  parameter int CNT_W = 16,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               clr_cnt,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   hold_cnt,
  output logic               stall_err
);
  if (SRC_STAGE + 1 >= STALL_W || DATA_W < 1) begin : g_bad_params
    $error("pipe_stage_reg: SRC_STAGE+1 must be < STALL_W and DATA_W >= 1");
  end
  logic s, d, bubble, hold, unused_stall;
  assign s = stall[SRC_STAGE];
  assign d = stall[SRC_STAGE+1];
  assign unused_stall = ^stall;
  // flush suppresses all counting and error detection, not just the payload update
  assign bubble = !flush && s && !d;
  assign hold = !flush && d;
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data <= BUBBLE_DATA;
      bubble_cnt <= '0;
      hold_cnt <= '0;
      stall_err <= 1'b0;
    end else begin
      if (flush || (s && !d)) begin
        out_valid <= 1'b0;
        out_data <= BUBBLE_DATA;
      end else if (!d) begin
        out_valid <= in_valid;
        out_data <= in_data;
      end
      if (clr_cnt) begin
        bubble_cnt <= '0;
        hold_cnt <= '0;
        stall_err <= 1'b0;
      end else begin
        if (bubble && bubble_cnt != '1) bubble_cnt <= bubble_cnt + 1'b1;
        if (hold && hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
        if (hold && !s) stall_err <= 1'b1;
      end
    end
  end
endmodule
